// File: rtl/cordic_front_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cordic_front_ctrl
// Purpose  : Front-end request controller for a CORDIC cos/sin engine.
//            Accepts a signed Q4.28 angle, folds it into [0, 2*pi), reduces it
//            to the first quadrant one subtraction per cycle, launches the
//            CORDIC, captures its result and hands it to the client under a
//            ready/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_front_ctrl #(
  parameter int              W       = 32,
  parameter logic [W-1:0]    HALF_PI = 32'h1921FB54,
  parameter logic [W-1:0]    TWO_PI  = 32'h6487ED51
) (
  input  logic         clk,
  input  logic         reset,
  // client request side
  input  logic         beg,
  input  logic [W-1:0] angle_in,
  input  logic         operation_in,
  input  logic         ack_out,
  // CORDIC result side
  input  logic         ready_CORDIC,
  input  logic [W-1:0] data_cordic,
  // CORDIC control side
  output logic         beg_FSM_CORDIC,
  output logic         ACK_FSM_CORDIC,
  output logic         operation,
  output logic [1:0]   shift_region_flag,
  output logic [W-1:0] angle_reduced,
  // client result side
  output logic         busy,
  output logic         ready,
  output logic [W-1:0] data_out,
  output logic         err
);

  // Signed views of the range constants so every comparison below is signed.
  localparam logic signed [W-1:0] HALF_PI_S  = HALF_PI;
  localparam logic signed [W-1:0] TWO_PI_S   = TWO_PI;
  localparam logic signed [W-1:0] NEG_TWO_PI = -TWO_PI_S;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NORM   = 3'd1,
    S_REDUCE = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_ACKC   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t             state;
  logic signed [W-1:0] acc;   // working angle during normalisation/reduction
  logic [1:0]          q;     // quadrant count accumulated during reduction

  // Out-of-range test for the latched angle: [-2*pi, 2*pi) is accepted.
  logic out_of_range;
  assign out_of_range = (acc >= TWO_PI_S) || (acc < NEG_TWO_PI);

  // Another quadrant can be removed while q has room and acc is >= pi/2.
  logic can_reduce;
  assign can_reduce = (q != 2'd3) && (acc >= HALF_PI_S);

  // Controller state machine; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      acc               <= '0;
      q                 <= 2'd0;
      beg_FSM_CORDIC    <= 1'b0;
      ACK_FSM_CORDIC    <= 1'b0;
      operation         <= 1'b0;
      shift_region_flag <= 2'd0;
      angle_reduced     <= '0;
      busy              <= 1'b0;
      ready             <= 1'b0;
      data_out          <= '0;
      err               <= 1'b0;
    end else begin
      // The two CORDIC strobes are single-cycle unless re-armed below.
      beg_FSM_CORDIC <= 1'b0;
      ACK_FSM_CORDIC <= 1'b0;

      case (state)
        S_IDLE: begin
          if (beg) begin
            acc       <= angle_in;
            operation <= operation_in;
            q         <= 2'd0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= S_NORM;
          end
        end

        S_NORM: begin
          if (out_of_range) begin
            // Reject without ever touching the CORDIC.
            err      <= 1'b1;
            data_out <= '0;
            ready    <= 1'b1;
            state    <= S_DONE;
          end else begin
            // Negative angles fold into [0, 2*pi); -2*pi lands exactly on 0.
            if (acc[W-1]) begin
              acc <= acc + TWO_PI_S;
            end
            state <= S_REDUCE;
          end
        end

        S_REDUCE: begin
          if (can_reduce) begin
            acc <= acc - HALF_PI_S;
            q   <= q + 2'd1;
          end else begin
            // Publish the reduced operand together with the start strobe so
            // the CORDIC sees stable inputs from START through ACKC.
            angle_reduced     <= acc;
            shift_region_flag <= q;
            beg_FSM_CORDIC    <= 1'b1;
            state             <= S_START;
          end
        end

        S_START: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (ready_CORDIC) begin
            data_out       <= data_cordic;
            ACK_FSM_CORDIC <= 1'b1;
            state          <= S_ACKC;
          end
        end

        S_ACKC: begin
          ready <= 1'b1;
          state <= S_DONE;
        end

        S_DONE: begin
          if (ack_out) begin
            ready <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        default: begin
          // Unreachable encoding: recover to a quiet idle.
          ready <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_front_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cordic_front_ctrl
// Purpose  : Directed, table-driven self-checking bench for cordic_front_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cordic_front_ctrl;

  localparam logic [31:0] HALF_PI = 32'h1921FB54;
  localparam logic [31:0] TWO_PI  = 32'h6487ED51;
  localparam logic [31:0] PI      = 32'h3243F6A8;

  logic        clk = 1'b0;
  logic        reset;
  logic        beg;
  logic [31:0] angle_in;
  logic        operation_in;
  logic        ack_out;
  logic        ready_CORDIC;
  logic [31:0] data_cordic;
  logic        beg_FSM_CORDIC;
  logic        ACK_FSM_CORDIC;
  logic        operation;
  logic [1:0]  shift_region_flag;
  logic [31:0] angle_reduced;
  logic        busy;
  logic        ready;
  logic [31:0] data_out;
  logic        err;

  cordic_front_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .beg               (beg),
    .angle_in          (angle_in),
    .operation_in      (operation_in),
    .ack_out           (ack_out),
    .ready_CORDIC      (ready_CORDIC),
    .data_cordic       (data_cordic),
    .beg_FSM_CORDIC    (beg_FSM_CORDIC),
    .ACK_FSM_CORDIC    (ACK_FSM_CORDIC),
    .operation         (operation),
    .shift_region_flag (shift_region_flag),
    .angle_reduced     (angle_reduced),
    .busy              (busy),
    .ready             (ready),
    .data_out          (data_out),
    .err               (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // All outputs packed together for the "everything cleared" checks.
  function automatic logic [79:0] all_outs();
    return {8'd0, beg_FSM_CORDIC, ACK_FSM_CORDIC, operation, shift_region_flag,
            angle_reduced, busy, ready, data_out, err};
  endfunction

  typedef struct {
    logic [31:0] angle;
    logic        op;
    int          dly;
    logic [31:0] dcor;
    logic [1:0]  q;
    logic [31:0] red;
    logic        err;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[9];

  // Issue one request and model the CORDIC: it answers dly WAIT cycles after
  // the start pulse. Returns the beg-to-ready latency and what was launched.
  task automatic run_op(input logic [31:0] a, input logic op, input int dly,
                        input logic [31:0] dc, output int lat, output int nb,
                        output int na, output logic [1:0] qs,
                        output logic [31:0] rs, output logic os);
    int wcnt;
    bit armed;
    nb = 0; na = 0; qs = 2'd0; rs = '0; os = 1'b0; armed = 0; wcnt = 0;
    @(negedge clk);
    beg = 1'b1; angle_in = a; operation_in = op;
    @(negedge clk);
    beg = 1'b0;
    lat = 1;
    while (!ready && lat < 300) begin
      ready_CORDIC = 1'b0;
      if (beg_FSM_CORDIC) begin
        nb++;
        qs = shift_region_flag; rs = angle_reduced; os = operation;
        armed = 1; wcnt = 0;
      end else if (armed) begin
        wcnt++;
        if (wcnt > dly) begin
          ready_CORDIC = 1'b1; data_cordic = dc; armed = 0;
        end
      end
      if (ACK_FSM_CORDIC) na++;
      @(negedge clk);
      lat++;
    end
    ready_CORDIC = 1'b0;
  endtask

  task automatic client_ack();
    @(negedge clk);
    ack_out = 1'b1;
    @(negedge clk);
    ack_out = 1'b0;
    chk("ack_ready_low", ready, 1'b0);
    chk("ack_busy_low", busy, 1'b0);
  endtask

  initial begin
    int lat, nb, na, exp_lat, n;
    logic [1:0]  qs;
    logic [31:0] rs;
    logic        os;

    reset = 1'b1; beg = 1'b0; angle_in = '0; operation_in = 1'b0;
    ack_out = 1'b0; ready_CORDIC = 1'b0; data_cordic = '0;

    //            angle                 op  dly dcor          q  red          err dout
    vecs[0] = '{32'h00000000,         0, 10, 32'h10000000, 0, 32'd0,         0, 32'h10000000};
    vecs[1] = '{PI,                   1,  3, 32'h0ABCDEF0, 2, 32'd0,         0, 32'h0ABCDEF0};
    vecs[2] = '{-HALF_PI,             0,  0, 32'hF0000000, 3, 32'd1,         0, 32'hF0000000};
    vecs[3] = '{TWO_PI,               1,  0, 32'h55555555, 0, 32'd0,         1, 32'h00000000};
    vecs[4] = '{-TWO_PI,              1,  2, 32'h00001234, 0, 32'd0,         0, 32'h00001234};
    vecs[5] = '{TWO_PI - 32'd1,       0,  1, 32'h7FFFFFFF, 3, 32'd421657428, 0, 32'h7FFFFFFF};
    vecs[6] = '{32'hFFFFFFFF - TWO_PI, 0, 0, 32'h11111111, 0, 32'd0,         1, 32'h00000000};
    vecs[7] = '{HALF_PI - 32'd1,      1,  4, 32'hCAFEF00D, 0, 32'd421657427, 0, 32'hCAFEF00D};
    vecs[8] = '{HALF_PI,              0,  2, 32'h0000BEEF, 1, 32'd0,         0, 32'h0000BEEF};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_outs(), '0);

    // Table-driven requests.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].angle, vecs[i].op, vecs[i].dly, vecs[i].dcor, lat, nb, na, qs, rs, os);
      exp_lat = vecs[i].err ? 2 : 6 + int'(vecs[i].q) + vecs[i].dly;
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
      chk($sformatf("v%0d_start_pulses", i), nb, vecs[i].err ? 0 : 1);
      chk($sformatf("v%0d_ack_pulses", i), na, vecs[i].err ? 0 : 1);
      chk($sformatf("v%0d_ready", i), ready, 1'b1);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_data_out", i), data_out, vecs[i].dout);
      if (!vecs[i].err) begin
        chk($sformatf("v%0d_region", i), qs, vecs[i].q);
        chk($sformatf("v%0d_angle_reduced", i), rs, vecs[i].red);
        chk($sformatf("v%0d_operation", i), os, vecs[i].op);
        chk($sformatf("v%0d_region_held", i), shift_region_flag, vecs[i].q);
      end
      client_ack();
    end

    // Handshake hold: DONE must hold through stray beg/ready_CORDIC.
    run_op(PI, 1'b0, 1, 32'h12345678, lat, nb, na, qs, rs, os);
    chk("hold_entry_ready", ready, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("hold_c%0d", k),
          {ready, beg_FSM_CORDIC, ACK_FSM_CORDIC, busy, data_out}, {4'b1001, 32'h12345678});
      beg          = (k % 3 == 0);
      angle_in     = $urandom;
      ready_CORDIC = (k == 5);
      data_cordic  = 32'hDEADBEEF;
    end
    beg = 1'b0; ready_CORDIC = 1'b0;
    client_ack();
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy || beg_FSM_CORDIC) n++;
    end
    chk("no_queued_beg", n, 0);

    // Reset during WAIT, then a late ready_CORDIC must do nothing.
    @(negedge clk);
    beg = 1'b1; angle_in = PI; operation_in = 1'b1;
    @(negedge clk);
    beg = 1'b0;
    n = 0;
    while (!beg_FSM_CORDIC && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_started", beg_FSM_CORDIC, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_wait_outputs", all_outs(), '0);
    reset = 1'b0;
    ready_CORDIC = 1'b1; data_cordic = 32'h87654321;
    @(negedge clk);
    ready_CORDIC = 1'b0;
    @(negedge clk);
    chk("late_ready_ignored", all_outs(), '0);

    // Reset in the middle of REDUCE.
    @(negedge clk);
    beg = 1'b1; angle_in = -HALF_PI; operation_in = 1'b1;
    @(negedge clk);
    beg = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_reduce_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_reduce_outputs", all_outs(), '0);
    reset = 1'b0;

    // Recovery after reset.
    run_op(PI, 1'b1, 2, 32'h0F0F0F0F, lat, nb, na, qs, rs, os);
    chk("recover_latency", lat, 6 + 2 + 2);
    chk("recover_region", qs, 2'd2);
    chk("recover_data", data_out, 32'h0F0F0F0F);
    client_ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
